// File: rtl/cpr_softrc_meas_ctrl.sv
// rtl/cpr_softrc_meas_ctrl.sv - soft CPR ring oscillator measurement controller
`timescale 1ns/100ps
module cpr_softrc_meas_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic [CNT_W-1:0] THRESH,
    output logic             PD_RC,
    input  logic             PDRC_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             SLOW,
    output logic             OVF
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int DRN_W = $clog2(SYNC_STAGES + 2);
    localparam int PH_A  = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam int PH_W  = (PH_A > DRN_W) ? PH_A : DRN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_prev;
    logic                   rise;
    logic [PH_W-1:0]        phase;
    logic [WIN_W-1:0]       win_q;
    logic [CNT_W-1:0]       thr_q;
    logic [CNT_W-1:0]       acc;
    logic                   ovf_acc;
    logic                   aborted;

    // Presets match the ring's idle-high level so release does not look like an edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= '1;
            edge_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], PDRC_IN};
            edge_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            PD_RC   <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            COUNT   <= '0;
            SLOW    <= 1'b0;
            OVF     <= 1'b0;
            phase   <= '0;
            win_q   <= '0;
            thr_q   <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            aborted <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        win_q   <= WIN_LEN;
                        thr_q   <= THRESH;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        aborted <= 1'b0;
                        if (WIN_LEN == '0) begin
                            state <= S_DONE;
                            DONE  <= 1'b1;
                            COUNT <= '0;
                            SLOW  <= (THRESH != '0);
                            OVF   <= 1'b0;
                        end else begin
                            state <= S_SETTLE;
                            PD_RC <= 1'b0;
                            BUSY  <= 1'b1;
                            phase <= PH_W'(SETTLE_CYC - 1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (ABORT) begin
                        state   <= S_DRAIN;
                        PD_RC   <= 1'b1;
                        aborted <= 1'b1;
                        phase   <= PH_W'(SYNC_STAGES);
                    end else if (phase == '0) begin
                        state <= S_MEASURE;
                        phase <= PH_W'(win_q) - PH_W'(1);
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        if (acc == {CNT_W{1'b1}})
                            ovf_acc <= 1'b1;
                        else
                            acc <= acc + CNT_W'(1);
                    end
                    if (ABORT || phase == '0) begin
                        state   <= S_DRAIN;
                        PD_RC   <= 1'b1;
                        aborted <= ABORT;
                        phase   <= PH_W'(SYNC_STAGES);
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Lets the forced-high ring edge flush through the synchroniser uncounted
                    if (phase == '0) begin
                        BUSY <= 1'b0;
                        if (aborted) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DONE;
                            DONE  <= 1'b1;
                            COUNT <= acc;
                            SLOW  <= (acc < thr_q);
                            OVF   <= ovf_acc;
                        end
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    PD_RC <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cpr_softrc_meas_ctrl.md
Name: cpr_softrc_meas_ctrl

Overview:
- Measurement controller for the soft critical-path-replica ring oscillator (OR-gated ring with power-down input PD_RC; output PDRCOut idles high while powered down).
- Per request: releases the ring from power-down, waits a settle time, then counts ring rising edges over a programmable window of system clocks.
- Returns the count and a slow-silicon flag versus a threshold. Sits beside the ring in the PM control logic; the ring output is treated as an asynchronous input and synchronised into CLK.

Parameters:
- CNT_W, 16: width of edge counter, COUNT and THRESH.
- WIN_W, 16: width of WIN_LEN (window length in CLK cycles).
- SETTLE_CYC, 8: CLK cycles after ring release before counting starts (must be >=1).
- SYNC_STAGES, 2: flops in the PDRC_IN synchroniser (must be >=2).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; sampled only in IDLE.
- ABORT  in  1  cancel the measurement in progress.
- WIN_LEN  in  WIN_W  measurement window in CLK cycles; latched on accepted START.
- THRESH  in  CNT_W  minimum acceptable edge count; latched on accepted START.
- PD_RC  out  1  ring power-down, registered; 1 = ring stopped.
- PDRC_IN  in  1  ring output PDRCOut, asynchronous to CLK.
- BUSY  out  1  high from accepted START until completion or abort drain ends.
- DONE  out  1  one-cycle pulse; result valid.
- COUNT  out  CNT_W  edge count of last completed measurement.
- SLOW  out  1  COUNT < THRESH for last completed measurement.
- OVF  out  1  counter saturated in last completed measurement.

Behaviour:
- Reset (async, RST=1):
  - State IDLE; PD_RC=1; BUSY=0, DONE=0, COUNT=0, SLOW=0, OVF=0.
  - Synchroniser flops and edge-detect history preset to 1, matching the ring idle-high level.
- Synchroniser and edge detect:
  - PDRC_IN passes through SYNC_STAGES flops.
  - Rising edge = last stage 1 and previous value 0.
  - Correct counting requires ring period > 2 CLK periods.
- States and transitions:
  - IDLE: PD_RC=1. START=1 and ABORT=0 latches WIN_LEN and THRESH and clears the accumulator and overflow. Then:
    - If WIN_LEN != 0, go to SETTLE.
    - If WIN_LEN == 0, go to DONE directly: PD_RC stays 1, result COUNT=0, SLOW=(THRESH!=0), OVF=0.
  - SETTLE: PD_RC=0. Lasts exactly SETTLE_CYC cycles; edges are ignored. Then go to MEASURE.
  - MEASURE: PD_RC=0. Lasts exactly WIN_LEN cycles. Each detected edge increments the accumulator, saturating at 2^CNT_W-1; an increment attempted at max sets the overflow flag. Then go to DRAIN.
  - DRAIN: PD_RC=1. Lasts SYNC_STAGES+1 cycles; edges are ignored, including the edge from the ring forced high. Then go to DONE, or to IDLE if entered via abort.
  - DONE: one cycle. DONE=1, BUSY=0. COUNT, SLOW and OVF update at the clock edge entering DONE and hold until the next DONE. Then go to IDLE.
- BUSY is 1 in SETTLE, MEASURE and DRAIN.
- Latency: START accepted at edge 0.
  - PD_RC=0 from edge 0.
  - DONE is high during cycle SETTLE_CYC+WIN_LEN+SYNC_STAGES+2 after edge 0.
- START while not IDLE is ignored; no queueing.
- ABORT:
  - In SETTLE or MEASURE: PD_RC=1 at the next edge and the state moves to DRAIN, then IDLE. No DONE pulse; COUNT, SLOW and OVF keep their previous values.
  - In DRAIN, DONE or IDLE: no effect, except that in IDLE it blocks a simultaneous START (ABORT wins).
- Accumulator and window counters are internal; the outputs change only on DONE.
- Reset mid-operation: immediate return to reset values, with PD_RC=1 asynchronously.

Test Plan:
1. Reset values: assert RST mid-MEASURE -> PD_RC=1 immediately; BUSY, DONE, COUNT, SLOW and OVF all 0; START after release is accepted.
2. Nominal run (CLK 2 ns, ring model 50 ns period while PD_RC=0, WIN_LEN=1000, THRESH=38):
   - DONE in cycle 8+1000+2+2=1012.
   - COUNT in 39..41, SLOW=0, OVF=0.
   - BUSY high for 1011 cycles.
3. Slow check: same stimulus with THRESH=50 -> SLOW=1, COUNT 39..41.
4. Saturation: CNT_W=4, WIN_LEN=1000 -> COUNT=15, OVF=1. A following run with WIN_LEN=100 -> COUNT in 3..5, OVF=0.
5. ABORT at cycle 20 of MEASURE:
   - PD_RC=1 next cycle; BUSY low after 3 drain cycles; no DONE pulse; COUNT holds the prior result.
   - START pulsed during BUSY is ignored.
   - START together with ABORT in IDLE does not start.
6. WIN_LEN=0 with THRESH=5 -> PD_RC stays 1, DONE one cycle after START, COUNT=0, SLOW=1, OVF=0.
